// File: rtl/palette_sched.sv
// Two-stage scheduler: iteration beats -> shared palette lookup -> registered colour out.
// Optional colour cycling is enabled by defining PALETTE_CYCLE_EN.
module palette_sched #(
    parameter int IW = 8,
    parameter int CW = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          frame_start,
    input  logic [1:0]    cfg_mode,
    input  logic [IW-1:0] cfg_max_iter,
    input  logic [7:0]    cfg_cycle_div,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] in_iter,
    output logic [IW-1:0] pal_iter,
    output logic [IW-1:0] pal_max_iter,
    output logic [1:0]    pal_mode,
    input  logic [CW-1:0] pal_rgb,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_rgb
);

    // Handshake: a beat moves on a rising edge when valid & ready are both high;
    // valid never drops and data never changes while a beat waits for ready.

    logic [1:0]    sh_mode_q, sh_mode_d;
    logic [IW-1:0] sh_max_q, sh_max_d;
    logic          s1_valid_q;
    logic [IW-1:0] pal_iter_q, pal_max_q;
    logic [1:0]    pal_mode_q;
    logic          out_valid_q;
    logic [CW-1:0] out_rgb_q;
    logic          s1_adv;
    logic          accept;
    logic [IW-1:0] eff_iter;

    // A beat accepted in the frame_start cycle already sees the new config.
    always_comb begin
        sh_mode_d = sh_mode_q;
        sh_max_d  = sh_max_q;
        if (frame_start) begin
            sh_mode_d = cfg_mode;
            sh_max_d  = cfg_max_iter;
        end
    end

`ifdef PALETTE_CYCLE_EN
    logic [7:0]  fcnt_q, fcnt_d;
    logic [IW-1:0] offset_q, offset_d;
    logic [IW:0] sum;
    logic [IW:0] wrapped;

    always_comb begin
        fcnt_d   = fcnt_q;
        offset_d = offset_q;
        if (frame_start) begin
            if ((cfg_cycle_div != 8'd0) && ({1'b0, fcnt_q} + 9'd1 == {1'b0, cfg_cycle_div})) begin
                fcnt_d = 8'd0;
                if ({1'b0, offset_q} + 9'd1 >= {1'b0, cfg_max_iter})
                    offset_d = '0;
                else
                    offset_d = offset_q + 1'b1;
            end else begin
                if (cfg_cycle_div != 8'd0)
                    fcnt_d = fcnt_q + 8'd1;
                // Keep offset < max so the effective iteration stays in range.
                if (cfg_max_iter <= offset_q)
                    offset_d = '0;
            end
        end
    end

    always_comb begin
        sum     = {1'b0, in_iter} + {1'b0, offset_d};
        wrapped = sum - {1'b0, sh_max_d};
        if (in_iter >= sh_max_d)
            eff_iter = in_iter;
        else if (sum >= {1'b0, sh_max_d})
            eff_iter = wrapped[IW-1:0];
        else
            eff_iter = sum[IW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_q   <= 8'd0;
            offset_q <= '0;
        end else begin
            fcnt_q   <= fcnt_d;
            offset_q <= offset_d;
        end
    end
`else
    logic unused_cycle_div;
    assign unused_cycle_div = ^cfg_cycle_div;
    assign eff_iter         = in_iter;
`endif

    assign s1_adv   = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s1_adv;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_mode_q   <= 2'd0;
            sh_max_q    <= '0;
            s1_valid_q  <= 1'b0;
            pal_iter_q  <= '0;
            pal_max_q   <= '0;
            pal_mode_q  <= 2'd0;
            out_valid_q <= 1'b0;
            out_rgb_q   <= '0;
        end else begin
            sh_mode_q <= sh_mode_d;
            sh_max_q  <= sh_max_d;
            if (in_ready) begin
                s1_valid_q <= in_valid;
            end
            // Each pixel carries its own config through the palette stage.
            if (accept) begin
                pal_iter_q <= eff_iter;
                pal_max_q  <= sh_max_d;
                pal_mode_q <= sh_mode_d;
            end
            if (s1_adv) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_rgb_q <= pal_rgb;
                end
            end
        end
    end

    assign pal_iter     = pal_iter_q;
    assign pal_max_iter = pal_max_q;
    assign pal_mode     = pal_mode_q;
    assign out_valid    = out_valid_q;
    assign out_rgb      = out_rgb_q;

endmodule
